// File: rtl/m_asm_pkg.sv
// Shared types and helpers for the instruction assembler.
// Holds the FSM state enum, control bit positions and slot count helper.
package m_asm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2
    } asm_state_t;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_CLEAR  = 1;

    // Number of payload slots needed to cover the assembled instruction.
    function automatic int nslot(input int word, input int dword, input int tag_w);
        int p;
        p = word - tag_w;
        return (dword + p - 1) / p;
    endfunction

endpackage

// File: rtl/m_instr_assembler_if.sv
// Decode-fragment input and context-request output bundle of the assembler.
// slave is the assembler side; master is the decoder/context side.
interface m_instr_assembler_if
    import m_asm_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int DWORD = 16,
    parameter int TAG_W = 2,
    parameter int NSLOT = nslot(WORD, DWORD, TAG_W)
);

    logic             decode_valid;
    logic [WORD-1:0]  decode;
    logic             decode_ready;
    logic             ack;
    logic             context_request;
    logic [DWORD-1:0] instruction;
    logic [NSLOT-1:0] slot_mask;

    modport master (
        output decode_valid,
        output decode,
        output ack,
        input  decode_ready,
        input  context_request,
        input  instruction,
        input  slot_mask
    );

    modport slave (
        input  decode_valid,
        input  decode,
        input  ack,
        output decode_ready,
        output context_request,
        output instruction,
        output slot_mask
    );

endinterface

// File: rtl/m_asm_slot_decode.sv
// Combinational fragment decoder: tag/payload to slot enables and
// positioned payload bits, plus control-fragment commit/clear flags.
module m_asm_slot_decode
    import m_asm_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int DWORD = 16,
    parameter int TAG_W = 2,
    parameter int P     = WORD - TAG_W,
    parameter int NSLOT = nslot(WORD, DWORD, TAG_W)
) (
    input  logic [TAG_W-1:0] tag_i,
    input  logic [P-1:0]     payload_i,
    output logic [NSLOT-1:0] wr_en_o,
    output logic [DWORD-1:0] wr_data_o,
    output logic [DWORD-1:0] wr_mask_o,
    output logic             is_ctrl_o,
    output logic             commit_o,
    output logic             clear_o
);

    // Place the payload at its slot; bits beyond the instruction are dropped.
    always_comb begin
        wr_en_o   = '0;
        wr_data_o = '0;
        wr_mask_o = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (tag_i == TAG_W'(k)) begin
                wr_en_o[k] = 1'b1;
                for (int j = 0; j < P; j++) begin
                    if (k * P + j < DWORD) begin
                        wr_data_o[k*P+j] = payload_i[j];
                        wr_mask_o[k*P+j] = 1'b1;
                    end
                end
            end
        end
        is_ctrl_o = &tag_i;
        clear_o   = is_ctrl_o & payload_i[CTRL_CLEAR];
        commit_o  = is_ctrl_o & payload_i[CTRL_COMMIT]
                  & ~payload_i[CTRL_CLEAR];
    end

endmodule

// File: rtl/m_instr_assembler.sv
// Instruction assembler: builds a DWORD instruction from tagged fragments
// and holds it behind a request/ack. Option: M_ASM_AUTOCOMMIT_EN.
module m_instr_assembler
    import m_asm_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int DWORD = 16,
    parameter int TAG_W = 2
) (
    input logic           clk,
    input logic           reset,
    m_instr_assembler_if.slave bus
);

    localparam int P     = WORD - TAG_W;
    localparam int NSLOT = nslot(WORD, DWORD, TAG_W);

    if (P < 2) begin : g_bad_payload
        $error("m_instr_assembler: payload narrower than control field");
    end
    if (NSLOT > (2 ** TAG_W) - 1) begin : g_bad_nslot
        $error("m_instr_assembler: NSLOT exceeds available slot tags");
    end

    asm_state_t       state_q, state_d;
    logic [DWORD-1:0] shadow_q, shadow_d;
    logic [DWORD-1:0] instr_q, instr_d;
    logic [NSLOT-1:0] mask_q, mask_d;

    logic [NSLOT-1:0] wr_en;
    logic [DWORD-1:0] wr_data;
    logic [DWORD-1:0] wr_mask;
    logic             is_ctrl;
    logic             commit;
    logic             clear;
    logic             accept;

    m_asm_slot_decode #(
        .WORD  (WORD),
        .DWORD (DWORD),
        .TAG_W (TAG_W),
        .P     (P),
        .NSLOT (NSLOT)
    ) u_dec (
        .tag_i     (bus.decode[WORD-1 -: TAG_W]),
        .payload_i (bus.decode[P-1:0]),
        .wr_en_o   (wr_en),
        .wr_data_o (wr_data),
        .wr_mask_o (wr_mask),
        .is_ctrl_o (is_ctrl),
        .commit_o  (commit),
        .clear_o   (clear)
    );

    assign bus.decode_ready    = (state_q != REQ);
    assign bus.context_request = (state_q == REQ);
    assign bus.instruction     = instr_q;
    assign bus.slot_mask       = mask_q;
    assign accept              = bus.decode_valid && bus.decode_ready;

    // Next state: slot writes, clear/commit control and ack release.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        instr_d  = instr_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (clear) begin
                        shadow_d = '0;
                        mask_d   = '0;
                        state_d  = IDLE;
                    end else if (commit) begin
                        instr_d  = shadow_q;
                        shadow_d = '0;
                        mask_d   = '0;
                        state_d  = REQ;
                    end else if (!is_ctrl && |wr_en) begin
                        shadow_d = (shadow_q & ~wr_mask) | wr_data;
                        mask_d   = mask_q | wr_en;
                        state_d  = FILL;
`ifdef M_ASM_AUTOCOMMIT_EN
                        if (&mask_d) begin
                            instr_d  = shadow_d;
                            shadow_d = '0;
                            mask_d   = '0;
                            state_d  = REQ;
                        end
`endif
                    end
                end
            end
            REQ: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow, mask and committed instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            mask_q   <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            instr_q  <= instr_d;
        end
    end

endmodule

// File: tb/tb_m_instr_assembler.sv
// Scoreboard bench for m_instr_assembler (default parameters).
// Works with and without M_ASM_AUTOCOMMIT_EN defined.
module tb_m_instr_assembler;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    logic [15:0] exp_q[$];
    logic        prev_req;

    m_instr_assembler_if #(.WORD(8), .DWORD(16), .TAG_W(2)) bus ();

    m_instr_assembler #(.WORD(8), .DWORD(16), .TAG_W(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each new request must match the next queued instruction.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req <= 1'b0;
        end else begin
            prev_req <= bus.context_request;
            if (bus.context_request && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_request: got instr 0x%0h expected none",
                             bus.instruction);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("sb_instruction", 32'(bus.instruction), 32'(e));
                    chk("sb_slot_mask", 32'(bus.slot_mask), 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] f);
        int n;
        n = 0;
        @(negedge clk);
        bus.decode_valid = 1'b1;
        bus.decode       = f;
        while (!bus.decode_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        bus.decode_valid = 1'b0;
    endtask

    task automatic do_ack(input logic [15:0] keep);
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("ack_req_low", 32'(bus.context_request), 32'd0);
        chk("ack_ready", 32'(bus.decode_ready), 32'd1);
        chk("ack_instr_keep", 32'(bus.instruction), 32'(keep));
    endtask

    // Loads CA95 slots; commits via control fragment unless autocommit.
    task automatic load_ca95();
        send(8'h15);
        chk("mask_s0", 32'(bus.slot_mask), 32'b001);
        send(8'h6A);
        chk("mask_s1", 32'(bus.slot_mask), 32'b011);
`ifdef M_ASM_AUTOCOMMIT_EN
        exp_q.push_back(16'hCA95);
        send(8'h8C);
`else
        send(8'h8C);
        chk("no_autocommit_req", 32'(bus.context_request), 32'd0);
        chk("mask_s2", 32'(bus.slot_mask), 32'b111);
        exp_q.push_back(16'hCA95);
        send(8'hC1);
`endif
        chk("commit_req", 32'(bus.context_request), 32'd1);
        chk("commit_instr", 32'(bus.instruction), 32'hCA95);
        chk("commit_mask", 32'(bus.slot_mask), 32'd0);
        chk("commit_ready", 32'(bus.decode_ready), 32'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        bus.decode_valid = 1'b0;
        bus.decode       = '0;
        bus.ack          = 1'b0;
        rst_n            = 1'b0;
        #12;
        chk("rst_req", 32'(bus.context_request), 32'd0);
        chk("rst_instr", 32'(bus.instruction), 32'd0);
        chk("rst_mask", 32'(bus.slot_mask), 32'd0);
        chk("rst_ready", 32'(bus.decode_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        load_ca95();
        do_ack(16'hCA95);

        send(8'h01);
        send(8'h3F);
        exp_q.push_back(16'h003F);
        send(8'hC1);
        do_ack(16'h003F);

        send(8'h7F);
        chk("mask_s1_only", 32'(bus.slot_mask), 32'b010);
        send(8'hC2);
        chk("clear_mask", 32'(bus.slot_mask), 32'd0);
        exp_q.push_back(16'h0000);
        send(8'hC1);
        chk("empty_commit_req", 32'(bus.context_request), 32'd1);
        do_ack(16'h0000);

        send(8'h7F);
        send(8'hC3);
        chk("both_req", 32'(bus.context_request), 32'd0);
        chk("both_mask", 32'(bus.slot_mask), 32'd0);
        chk("both_ready", 32'(bus.decode_ready), 32'd1);
        chk("both_instr", 32'(bus.instruction), 32'd0);

        exp_q.push_back(16'h0000);
        send(8'hC1);
        @(negedge clk);
        bus.decode_valid = 1'b1;
        bus.decode       = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.decode_ready), 32'd0);
            chk("bp_mask", 32'(bus.slot_mask), 32'd0);
        end
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ack = 1'b0;
        chk("bp_release_ready", 32'(bus.decode_ready), 32'd1);
        chk("bp_release_mask", 32'(bus.slot_mask), 32'd0);
        @(posedge clk);
        #1;
        bus.decode_valid = 1'b0;
        chk("bp_accept_mask", 32'(bus.slot_mask), 32'b001);
        send(8'hC2);

        load_ca95();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.context_request), 32'd0);
        chk("arst_instr", 32'(bus.instruction), 32'd0);
        chk("arst_ready", 32'(bus.decode_ready), 32'd1);
        chk("arst_mask", 32'(bus.slot_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
